// File: rtl/alu_share_pkg.sv
// Shared types and constants for the two-port ALU sharing arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_share_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 4;
    localparam int SH_W_DEF   = 5;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // ALU control encodings, matching the shared ALU instance
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRL = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1011;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant selection; ALU_ARB_FIXED_PRIO_EN selects fixed port-0 priority.
// Latency: combinational, grant in the same cycle as the requests.
// Backpressure: none; the caller qualifies the grant with its own busy state.
module rr_arb2 (
    input  logic       [1:0] req,
    input  logic             ptr,
    input  logic             ptr_vld,
    output logic       [1:0] gnt
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Pointer is irrelevant when port 0 always has priority
    logic unused_ptr;
    assign unused_ptr = ptr ^ ptr_vld;

    // Fixed priority: port 0 beats port 1 whenever it requests
    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`else
    // Round-robin: a sole requester wins; on a tie the port other than the
    // last-granted one wins. Until the first grant after reset there is no
    // history (ptr_vld low), and port 0 takes the tie.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (ptr_vld && (ptr == 1'b0)) ? 2'b10 : 2'b01;
        end
    end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with registered operands and results.
// Latency: accept edge to rsp_valid is 2 cycles; one op in flight, best case 1 op per 3 cycles.
// Backpressure: req*_ready low while an op is in flight; response held until rspG_ready.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int SH_W   = SH_W_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SH_W-1:0]   req0_shamt,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SH_W-1:0]   req1_shamt,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,

    output logic [DATA_W-1:0] aluIn1,
    output logic [DATA_W-1:0] aluIn2,
    output logic [OP_W-1:0]   aluControl,
    output logic [SH_W-1:0]   shamt,
    input  logic [DATA_W-1:0] aluResult,
    input  logic              zero
);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        req_vld;
    logic [1:0]        gnt;
    logic              gnt_q;      // port index of the op in flight
    logic              ptr;        // last port whose response completed
    logic              ptr_vld;    // a grant has completed since reset
    logic              accept;
    logic              rsp_done;
    logic [DATA_W-1:0] res_q;
    logic              zero_q;

    assign req_vld = {req1_valid, req0_valid};

    rr_arb2 u_arb (
        .req     (req_vld),
        .ptr     (ptr),
        .ptr_vld (ptr_vld),
        .gnt     (gnt)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs; ready is masked during reset so all
    // handshake outputs read 0 while reset is asserted.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    req0_ready = gnt[0];
                    req1_ready = gnt[1];
                end
                if (|req_vld) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp0_valid = ~gnt_q;
                rsp1_valid = gnt_q;
                if (gnt_q ? rsp1_ready : rsp0_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winner's operands into the ALU drive registers on acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q      <= 1'b0;
            aluIn1     <= '0;
            aluIn2     <= '0;
            aluControl <= '0;
            shamt      <= '0;
        end else if (accept) begin
            gnt_q      <= gnt[1];
            aluIn1     <= gnt[1] ? req1_a     : req0_a;
            aluIn2     <= gnt[1] ? req1_b     : req0_b;
            aluControl <= gnt[1] ? req1_op    : req0_op;
            shamt      <= gnt[1] ? req1_shamt : req0_shamt;
        end
    end

    // Capture ALU outputs after the operands have been stable for a full cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q  <= '0;
            zero_q <= 1'b0;
        end else if (state == ISSUE) begin
            res_q  <= aluResult;
            zero_q <= zero;
        end
    end

    // Round-robin history advances only when a response completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= 1'b0;
            ptr_vld <= 1'b0;
        end else if (rsp_done) begin
            ptr     <= gnt_q;
            ptr_vld <= 1'b1;
        end
    end

    // Both response ports see the captured value; only valid selects the owner
    assign rsp0_result = res_q;
    assign rsp1_result = res_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural ALU and reference model.
// Latency: n/a.
// Backpressure: exercised by holding rsp*_ready low and by random ready patterns.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int SW = 5;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
    logic [OW-1:0] req0_op;
    logic [DW-1:0] req0_a, req0_b, rsp0_result;
    logic [SW-1:0] req0_shamt;
    logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [OW-1:0] req1_op;
    logic [DW-1:0] req1_a, req1_b, rsp1_result;
    logic [SW-1:0] req1_shamt;
    logic [DW-1:0] aluIn1, aluIn2, aluResult;
    logic [OW-1:0] aluControl;
    logic [SW-1:0] shamt;
    logic          zero;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] op_tab [9] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT,
                                ALU_SLL, ALU_SRL, ALU_XOR, ALU_NOR};

    // Behavioural ALU: what the shared ALU computes from its inputs
    function automatic logic [DW-1:0] ref_alu(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b, input logic [SW-1:0] sh);
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL: return b << sh;
            ALU_SRL: return b >> sh;
            ALU_XOR: return a ^ b;
            ALU_NOR: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    assign aluResult = ref_alu(aluControl, aluIn1, aluIn2, shamt);
    assign zero      = (aluIn1 == aluIn2);

    alu_share_arbiter dut (
        .clk(clk), .reset(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .aluIn1(aluIn1), .aluIn2(aluIn2), .aluControl(aluControl), .shamt(shamt),
        .aluResult(aluResult), .zero(zero)
    );

    task automatic set_req(input int p, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        if (p == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_shamt = sh;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_shamt = sh;
        end
    endtask

    task automatic set_rand_req(input int p);
        logic [31:0] a = $urandom;
        logic [31:0] b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        set_req(p, 1'b1, op_tab[$urandom_range(0, 8)], a, b, 5'($urandom_range(0, 31)));
    endtask

    // Called at a negedge with inputs driven; returns granted port or -1
    task automatic wait_ready(output int port);
        port = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready) begin port = 0; return; end
            if (req1_ready) begin port = 1; return; end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(input int p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((p == 0) ? rsp0_valid : rsp1_valid) begin ok = 1'b1; return; end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_req(0, 1'b0, '0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2, 5'd0);
        set_req(1, 1'b1, ALU_ADD, 32'd3, 32'd4, 5'd0);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #2;
        n_cmp++;
        if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid} !== 4'b0000) begin
            n_err++; $display("FAIL reset_handshake got=%b exp=0000", {req1_ready, req0_ready, rsp1_valid, rsp0_valid});
        end
        n_cmp++;
        if ({aluIn1, aluIn2, aluControl, shamt} !== '0) begin
            n_err++; $display("FAIL reset_alu_drive got=%h/%h/%h/%h exp=0", aluIn1, aluIn2, aluControl, shamt);
        end
        n_cmp++;
        if ({rsp0_result, rsp0_zero, rsp1_result, rsp1_zero} !== '0) begin
            n_err++; $display("FAIL reset_result got=%h/%b exp=0", rsp0_result, rsp0_zero);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b0, '0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic test_contention();
        int p;
        bit ok;
        int exp_p;
        logic [31:0] er;
        logic ez;
        do_reset();
        set_req(0, 1'b1, ALU_SUB, 32'd9, 32'd9, 5'd0);
        set_req(1, 1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
        for (int k = 0; k < 6; k++) begin
            wait_ready(p);
            exp_p = FIXED ? 0 : (k % 2);
            n_cmp++;
            if (p != exp_p) begin
                n_err++; $display("FAIL contention_grant[%0d] got=%0d exp=%0d", k, p, exp_p);
                return;
            end
            er = (p == 0) ? ref_alu(req0_op, req0_a, req0_b, req0_shamt)
                          : ref_alu(req1_op, req1_a, req1_b, req1_shamt);
            ez = (p == 0) ? (req0_a == req0_b) : (req1_a == req1_b);
            if (k == 0) begin
                n_cmp++;
                if ({er, ez} !== {32'd0, 1'b1}) begin
                    n_err++; $display("FAIL contention_model_first got=%h/%b exp=0/1", er, ez);
                end
            end
            @(negedge clk);
            set_rand_req(p);
            wait_rsp(p, ok);
            n_cmp++;
            if (!ok || ((p == 0) ? rsp0_result : rsp1_result) !== er
                    || ((p == 0) ? rsp0_zero : rsp1_zero) !== ez) begin
                n_err++; $display("FAIL contention_result[%0d] got=%h/%b exp=%h/%b valid=%b", k,
                                  (p == 0) ? rsp0_result : rsp1_result,
                                  (p == 0) ? rsp0_zero : rsp1_zero, er, ez, ok);
            end
            @(negedge clk);
        end
        set_req(0, 1'b0, '0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0, '0);
        @(negedge clk);
    endtask

    task automatic test_single_op();
        @(negedge clk);
        set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7, 5'd0);
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_err++; $display("FAIL single_ready got=%b exp=01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        n_cmp++;
        if ({rsp0_valid, aluIn1, aluIn2, aluControl} !== {1'b0, 32'd5, 32'd7, ALU_ADD}) begin
            n_err++; $display("FAIL single_issue got=%b/%h/%h/%h exp=0/5/7/2", rsp0_valid, aluIn1, aluIn2, aluControl);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({rsp1_valid, rsp0_valid, rsp0_result, rsp0_zero} !== {2'b01, 32'd12, 1'b0}) begin
            n_err++; $display("FAIL single_rsp got=%b%b/%h/%b exp=01/c/0", rsp1_valid, rsp0_valid, rsp0_result, rsp0_zero);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (rsp0_valid !== 1'b0) begin
            n_err++; $display("FAIL single_rsp_clear got=%b exp=0", rsp0_valid);
        end
    endtask

    task automatic test_backpressure();
        int p;
        bit ok;
        @(negedge clk);
        rsp1_ready = 1'b0;
        set_req(1, 1'b1, ALU_SLL, 32'h0000_FFFF, 32'h0000_FFFF, 5'd16);
        wait_ready(p);
        n_cmp++;
        if (p != 1) begin
            n_err++; $display("FAIL bp_grant got=%0d exp=1", p);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        set_req(0, 1'b1, ALU_AND, 32'd3, 32'd5, 5'd0);
        wait_rsp(1, ok);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (!ok || {rsp1_valid, rsp1_result, req0_ready} !== {1'b1, 32'hFFFF_0000, 1'b0}) begin
                n_err++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/ffff0000/0", i, rsp1_valid, rsp1_result, req0_ready);
            end
            @(negedge clk);
            #1;
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({rsp1_valid, req0_ready} !== 2'b01) begin
            n_err++; $display("FAIL bp_release got=%b exp=01", {rsp1_valid, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        wait_rsp(0, ok);
        n_cmp++;
        if (!ok || rsp0_result !== 32'd1) begin
            n_err++; $display("FAIL bp_next_result got=%h exp=1 valid=%b", rsp0_result, ok);
        end
        @(negedge clk);
    endtask

    task automatic test_undef_op();
        int p;
        bit ok;
        set_req(0, 1'b1, 4'b1111, 32'd3, 32'd3, 5'd0);
        wait_ready(p);
        n_cmp++;
        if (p != 0) begin
            n_err++; $display("FAIL undef_grant got=%0d exp=0", p);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        wait_rsp(0, ok);
        n_cmp++;
        if (!ok || {rsp0_result, rsp0_zero, aluControl} !== {32'd0, 1'b1, 4'b1111}) begin
            n_err++; $display("FAIL undef_result got=%h/%b/%h exp=0/1/f valid=%b", rsp0_result, rsp0_zero, aluControl, ok);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int p;
        bit ok;
        set_req(1, 1'b1, ALU_ADD, 32'd1, 32'd2, 5'd3);
        wait_ready(p);
        @(negedge clk);
        req1_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({aluIn1, aluIn2, aluControl, shamt, rsp0_valid, rsp1_valid, rsp1_result} !== '0) begin
            n_err++; $display("FAIL midreset_outputs got=%h/%h/%h/%h/%b%b exp=0", aluIn1, aluIn2, aluControl, shamt, rsp1_valid, rsp0_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b1, ALU_OR, 32'h10, 32'h01, 5'd0);
        set_req(1, 1'b1, ALU_OR, 32'h20, 32'h02, 5'd0);
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_err++; $display("FAIL midreset_tie got=%b exp=01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        set_req(0, 1'b0, '0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0, '0);
        wait_rsp(0, ok);
        n_cmp++;
        if (!ok || rsp1_valid !== 1'b0 || rsp0_result !== 32'h11) begin
            n_err++; $display("FAIL midreset_after got=%h rsp1_valid=%b exp=11/0 valid=%b", rsp0_result, rsp1_valid, ok);
        end
        @(negedge clk);
    endtask

    // Random traffic against a transaction-level model: one op in flight,
    // response two cycles after acceptance, grant rule from port history.
    task automatic test_random();
        int last = -1;
        bit busy = 1'b0;
        int cur = 0;
        int acc_it = 0;
        int w;
        bit hold [2] = '{1'b0, 1'b0};
        logic [31:0] er = '0;
        logic ez = 1'b0;
        logic [1:0] exp_rdy, exp_rv;
        do_reset();
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!hold[p] && $urandom_range(0, 2) == 0) begin
                    set_rand_req(p);
                    hold[p] = 1'b1;
                end
            end
            req0_valid = hold[0];
            req1_valid = hold[1];
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            #1;
            w = -1;
            if (!busy) begin
                if (hold[0] && hold[1]) w = FIXED ? 0 : ((last == 0) ? 1 : 0);
                else if (hold[0]) w = 0;
                else if (hold[1]) w = 1;
            end
            exp_rdy = (w < 0) ? 2'b00 : 2'(1 << w);
            n_cmp++;
            if ({req1_ready, req0_ready} !== exp_rdy) begin
                n_err++; $display("FAIL rand_ready it=%0d got=%b exp=%b", it, {req1_ready, req0_ready}, exp_rdy);
            end
            exp_rv = (busy && it >= acc_it + 2) ? 2'(1 << cur) : 2'b00;
            n_cmp++;
            if ({rsp1_valid, rsp0_valid} !== exp_rv) begin
                n_err++; $display("FAIL rand_rsp_valid it=%0d got=%b exp=%b", it, {rsp1_valid, rsp0_valid}, exp_rv);
            end
            if (exp_rv != 2'b00) begin
                n_cmp++;
                if (((cur == 0) ? rsp0_result : rsp1_result) !== er || ((cur == 0) ? rsp0_zero : rsp1_zero) !== ez) begin
                    n_err++; $display("FAIL rand_result it=%0d got=%h/%b exp=%h/%b", it,
                                      (cur == 0) ? rsp0_result : rsp1_result,
                                      (cur == 0) ? rsp0_zero : rsp1_zero, er, ez);
                end
            end
            if (w >= 0) begin
                busy = 1'b1; cur = w; acc_it = it; hold[w] = 1'b0;
                er = (w == 0) ? ref_alu(req0_op, req0_a, req0_b, req0_shamt)
                              : ref_alu(req1_op, req1_a, req1_b, req1_shamt);
                ez = (w == 0) ? (req0_a == req0_b) : (req1_a == req1_b);
            end else if (busy && it >= acc_it + 2 && ((cur == 0) ? rsp0_ready : rsp1_ready)) begin
                busy = 1'b0; last = cur;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_contention();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        test_single_op();
        test_backpressure();
        test_undef_op();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
